// File: rtl/sn74ls93_capture.sv
// Capture stage for an sn74ls93/sn74ls90-style ripple counter: synchronizes the
// dcba outputs, rejects ripple transients, and extends the count to 8 bits.
module sn74ls93_capture #(
  parameter int MODULUS     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] d,
  input  logic       le,
  output logic [7:0] q,
  output logic       wrap,
  output logic       valid,
  output logic       err,
  output logic       ovf
);

  if (!(MODULUS == 10 || MODULUS == 16)) begin : g_bad_modulus
    $error("sn74ls93_capture: MODULUS must be 10 or 16");
  end
  if (!(SYNC_STAGES == 2 || SYNC_STAGES == 3)) begin : g_bad_sync
    $error("sn74ls93_capture: SYNC_STAGES must be 2 or 3");
  end

  localparam logic [4:0] MOD_LIMIT = 5'(MODULUS);

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [SYNC_STAGES-1:0]      fill_q;
  logic [3:0]                  s;
  logic [3:0]                  s_ahead;
  logic                        stable;

  logic [3:0] lo_q,    lo_d;
  logic [3:0] hi_q,    hi_d;
  logic [7:0] q_q,     q_d;
  logic       wrap_q,  wrap_d;
  logic       valid_q, valid_d;
  logic       err_q,   err_d;
  logic       ovf_q,   ovf_d;

  // fill_q marks which synchronizer stages hold a real post-reset sample, so
  // the all-zero reset contents are never mistaken for a stable count.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage shift from the old
      // value of its predecessor; blocking ones would collapse the chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // s is stable when the stage behind it already holds the same value, so the
  // filter decides without waiting an extra cycle: latency is SYNC_STAGES+1.
  assign s       = sync_q[SYNC_STAGES-1];
  assign s_ahead = sync_q[SYNC_STAGES-2];
  assign stable  = fill_q[SYNC_STAGES-1] && (s == s_ahead);

  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise paths
    // that skip an assignment would infer a latch.
    lo_d    = lo_q;
    hi_d    = hi_q;
    valid_d = valid_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    wrap_d  = 1'b0;

    if (stable) begin
      if ({1'b0, s} >= MOD_LIMIT) begin
        err_d = 1'b1;
      end else if (!valid_q) begin
        lo_d    = s;
        valid_d = 1'b1;
      end else begin
        // Any decrease is one wrap, however many counts were skipped.
        if (s < lo_q) begin
          hi_d   = hi_q + 4'd1;
          wrap_d = 1'b1;
          if (hi_q == 4'hF) begin
            ovf_d = 1'b1;
          end
        end
        lo_d = s;
      end
    end

    q_d = le ? {hi_d, lo_d} : q_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      lo_q    <= '0;
      hi_q    <= '0;
      q_q     <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      q_q     <= q_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q     = q_q;
  assign wrap  = wrap_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_sn74ls93_capture.sv
// Scoreboard bench: stimulus queues expected {q, wrap} output events, and one
// monitor per instance pops and compares whenever q changes or wrap pulses.
module tb_sn74ls93_capture;

  typedef struct packed {
    logic [7:0] q;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr16 = 1'b0, le16 = 1'b1;
  logic [3:0] d16 = 4'd0;
  logic [7:0] q16;
  logic       wrap16, valid16, err16, ovf16;
  logic       clr10 = 1'b0, le10 = 1'b1;
  logic [3:0] d10 = 4'd0;
  logic [7:0] q10;
  logic       wrap10, valid10, err10, ovf10;

  exp_t exp16[$];
  exp_t exp10[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sn74ls93_capture #(.MODULUS(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .clr(clr16), .d(d16), .le(le16),
    .q(q16), .wrap(wrap16), .valid(valid16), .err(err16), .ovf(ovf16)
  );

  sn74ls93_capture #(.MODULUS(10), .SYNC_STAGES(2)) dut10 (
    .clk(clk), .clr(clr10), .d(d10), .le(le10),
    .q(q10), .wrap(wrap10), .valid(valid10), .err(err10), .ovf(ovf10)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Leaves the stimulus 2 time units after a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic push16(input logic [7:0] qv, input logic w);
    exp_t e;
    e.q = qv;
    e.wrap = w;
    exp16.push_back(e);
  endtask

  task automatic push10(input logic [7:0] qv, input logic w);
    exp_t e;
    e.q = qv;
    e.wrap = w;
    exp10.push_back(e);
  endtask

  initial begin : mon16
    logic [7:0] prev;
    exp_t e;
    prev = 8'h00;
    forever begin
      @(negedge clk);
      if (q16 !== prev || wrap16 === 1'b1) begin
        n_vec++;
        if (exp16.size() == 0) begin
          n_err++;
          $display("FAIL mon16 unexpected: got q=%02h wrap=%b, required no output event", q16, wrap16);
        end else begin
          e = exp16.pop_front();
          if (q16 !== e.q || wrap16 !== e.wrap) begin
            n_err++;
            $display("FAIL mon16: got q=%02h wrap=%b, required q=%02h wrap=%b", q16, wrap16, e.q, e.wrap);
          end
        end
      end
      prev = q16;
    end
  end

  initial begin : mon10
    logic [7:0] prev;
    exp_t e;
    prev = 8'h00;
    forever begin
      @(negedge clk);
      if (q10 !== prev || wrap10 === 1'b1) begin
        n_vec++;
        if (exp10.size() == 0) begin
          n_err++;
          $display("FAIL mon10 unexpected: got q=%02h wrap=%b, required no output event", q10, wrap10);
        end else begin
          e = exp10.pop_front();
          if (q10 !== e.q || wrap10 !== e.wrap) begin
            n_err++;
            $display("FAIL mon10: got q=%02h wrap=%b, required q=%02h wrap=%b", q10, wrap10, e.q, e.wrap);
          end
        end
      end
      prev = q10;
    end
  end

  initial begin
    #1;
    clr16 = 1'b1;
    clr10 = 1'b1;
    d16   = 4'd5;
    tick(1);

    // Reset state and 3-edge latency
    check("reset q", q16, 8'h00);
    check("reset valid", valid16, 1'b0);
    push16(8'h05, 1'b0);
    clr16 = 1'b0;
    tick(2);
    check("latency valid after 2 edges", valid16, 1'b0);
    check("latency q after 2 edges", q16, 8'h00);
    tick(1);
    check("latency q after 3 edges", q16, 8'h05);
    check("latency valid after 3 edges", valid16, 1'b1);

    // Binary wrap 14,15,0,1
    d16 = 4'd14; push16(8'h0E, 1'b0); tick(6);
    d16 = 4'd15; push16(8'h0F, 1'b0); tick(6);
    d16 = 4'd0;  push16(8'h10, 1'b1); tick(6);
    d16 = 4'd1;  push16(8'h11, 1'b0); tick(6);
    check("binary final q", q16, 8'h11);

    // Ripple glitch rejection 7->6->4->0->8
    push16(8'h00, 1'b0);
    clr16 = 1'b1;
    d16   = 4'd7;
    tick(1);
    clr16 = 1'b0;
    push16(8'h07, 1'b0);
    tick(6);
    check("glitch start q", q16, 8'h07);
    push16(8'h08, 1'b0);
    d16 = 4'd6; tick(1);
    d16 = 4'd4; tick(1);
    d16 = 4'd0; tick(1);
    d16 = 4'd8; tick(6);
    check("glitch end q", q16, 8'h08);

    // Hold with le=0 across a wrap
    le16 = 1'b0;
    push16(8'h08, 1'b1);
    d16 = 4'd2;
    tick(6);
    check("hold q frozen", q16, 8'h08);
    le16 = 1'b1;
    push16(8'h12, 1'b0);
    tick(2);
    check("hold released q", q16, 8'h12);

    // 16 wraps from hi=0 -> ovf
    push16(8'h00, 1'b0);
    clr16 = 1'b1;
    d16   = 4'd0;
    tick(1);
    clr16 = 1'b0;
    tick(6);
    for (int k = 0; k < 16; k++) begin
      d16 = 4'd5; push16({4'(k), 4'd5}, 1'b0); tick(6);
      d16 = 4'd0; push16({4'(k + 1), 4'd0}, 1'b1); tick(6);
      if (k == 14) check("ovf clear after 15 wraps", ovf16, 1'b0);
    end
    check("ovf set after 16 wraps", ovf16, 1'b1);
    check("hi back to 0", q16, 8'h00);
    for (int k = 0; k < 3; k++) begin
      d16 = 4'd5; push16({4'(k), 4'd5}, 1'b0); tick(6);
      d16 = 4'd0; push16({4'(k + 1), 4'd0}, 1'b1); tick(6);
    end
    d16 = 4'd10;
    push16(8'h3A, 1'b0);
    tick(6);
    check("pre-reset q", q16, 8'h3A);

    // Mid-operation half-period reset
    push16(8'h00, 1'b0);
    @(posedge clk);
    #2;
    clr16 = 1'b1;
    #1;
    check("async reset q", q16, 8'h00);
    check("async reset valid", valid16, 1'b0);
    check("async reset ovf", ovf16, 1'b0);
    check("async reset wrap", wrap16, 1'b0);
    @(negedge clk);
    #2;
    clr16 = 1'b0;
    push16(8'h0A, 1'b0);
    tick(2);
    check("restart valid after 2 edges", valid16, 1'b0);
    tick(1);
    check("restart q after 3 edges", q16, 8'h0A);
    check("restart valid after 3 edges", valid16, 1'b1);

    // Decade mode: three full 0..9,0 passes
    clr10 = 1'b0;
    d10   = 4'd0;
    tick(6);
    for (int r = 0; r < 3; r++) begin
      for (int v = 1; v < 10; v++) begin
        d10 = 4'(v);
        push10({4'(r), 4'(v)}, 1'b0);
        tick(6);
      end
      d10 = 4'd0;
      push10({4'(r + 1), 4'd0}, 1'b1);
      tick(6);
    end
    check("decade final q", q10, 8'h30);
    check("decade err clear", err10, 1'b0);
    d10 = 4'd12;
    tick(6);
    check("decade err on 12", err10, 1'b1);
    check("decade q held on 12", q10, 8'h30);
    d10 = 4'd0;
    tick(6);
    check("decade err sticky", err10, 1'b1);
    check("decade q after return", q10, 8'h30);
    push10(8'h00, 1'b0);
    @(posedge clk);
    #2;
    clr10 = 1'b1;
    #1;
    check("decade reset err", err10, 1'b0);
    check("decade reset q", q10, 8'h00);
    @(negedge clk);
    #2;
    clr10 = 1'b0;

    tick(4);
    check("scoreboard16 drained", exp16.size(), 0);
    check("scoreboard10 drained", exp10.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
